// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings and decode helpers for the load/store unit
package lsu_pkg;

  localparam int DECODE_W = 46;

  // Bit positions of the memory ops inside the 46-bit decode one-hot net
  localparam int IS_LB  = 11;
  localparam int IS_LH  = 12;
  localparam int IS_LW  = 13;
  localparam int IS_LBU = 14;
  localparam int IS_LHU = 15;
  localparam int IS_SB  = 16;
  localparam int IS_SH  = 17;
  localparam int IS_SW  = 18;

  localparam logic [1:0] LSU_IDLE = 2'd0;
  localparam logic [1:0] LSU_REQ  = 2'd1;
  localparam logic [1:0] LSU_DONE = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef struct packed {
    logic       is_mem;
    logic       is_store;
    logic       is_signed;
    logic [1:0] size;
  } lsu_op_t;

  // ops ordering: {sw, sh, sb, lhu, lbu, lw, lh, lb}
  function automatic lsu_op_t lsu_decode(input logic [7:0] ops);
    lsu_op_t op;
    op           = '0;
    op.is_mem    = |ops;
    op.is_store  = ops[7] | ops[6] | ops[5];
    op.is_signed = ops[0] | ops[1];
    if (ops[1] | ops[4] | ops[6]) begin
      op.size = SZ_HALF;
    end else if (ops[2] | ops[7]) begin
      op.size = SZ_WORD;
    end else begin
      op.size = SZ_BYTE;
    end
    return op;
  endfunction

  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      SZ_HALF: mis = off[0];
      SZ_WORD: mis = |off;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane replication/strobes and load extraction/extension
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte      = 8'(i_rdata >> {i_off, 3'b000});
    w_half      = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_wdata     = i_store_data;
    o_wstrb     = 4'b1111;
    o_load_data = i_rdata;
    case (i_size)
      SZ_BYTE: begin
        o_wdata     = {4{i_store_data[7:0]}};
        o_wstrb     = 4'b0001 << i_off;
        o_load_data = i_signed ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
      end
      SZ_HALF: begin
        o_wdata     = {2{i_store_data[15:0]}};
        o_wstrb     = 4'b0011 << i_off;
        o_load_data = i_signed ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: one data-bus transaction per start pulse
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [DECODE_W-1:0] decode_net_i,
  input  logic [31:0]         address_i,
  input  logic [31:0]         rs2_val_i,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [31:0]         mem_addr_o,
  output logic [31:0]         mem_wdata_o,
  output logic [3:0]          mem_wstrb_o,
  input  logic                mem_ready_i,
  input  logic [31:0]         mem_rdata_i,
  output logic [31:0]         load_data_o,
  output logic                done_o,
  output logic                busy_o,
  output logic                misaligned_o,
  output logic                bus_err_o
);

  localparam logic [7:0] TIMEOUT = 8'(TIMEOUT_CYCLES);

  logic [1:0]  r_state;
  logic [31:0] r_addr;
  logic [31:0] r_store_data;
  logic        r_is_store;
  logic        r_signed;
  logic [1:0]  r_size;
  logic [7:0]  r_count;
  logic        r_misaligned;
  logic        r_bus_err;
  logic [31:0] r_load_data;

  lsu_op_t     w_op;
  logic        w_misaligned;
  logic        w_timeout;
  logic        w_req;
  logic        w_wr;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;
  logic [31:0] w_load_data;
  logic        w_unused_decode;

  assign w_op = lsu_decode({decode_net_i[IS_SW], decode_net_i[IS_SH], decode_net_i[IS_SB],
                            decode_net_i[IS_LHU], decode_net_i[IS_LBU], decode_net_i[IS_LW],
                            decode_net_i[IS_LH], decode_net_i[IS_LB]});
  assign w_unused_decode = ^decode_net_i;

  assign w_misaligned = w_op.is_mem && lsu_misaligned(w_op.size, address_i[1:0]);
  // The request drops in the cycle the counter hits the limit; DONE follows one cycle later
  assign w_timeout    = (r_count == TIMEOUT);
  assign w_req        = (r_state == LSU_REQ) && !w_timeout;
  assign w_wr         = w_req && r_is_store;

  lsu_align u_align (
    .i_off        (r_addr[1:0]),
    .i_size       (r_size),
    .i_signed     (r_signed),
    .i_store_data (r_store_data),
    .i_rdata      (mem_rdata_i),
    .o_wdata      (w_wdata),
    .o_wstrb      (w_wstrb),
    .o_load_data  (w_load_data)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= LSU_IDLE;
      r_addr       <= '0;
      r_store_data <= '0;
      r_is_store   <= 1'b0;
      r_signed     <= 1'b0;
      r_size       <= SZ_BYTE;
      r_count      <= '0;
      r_misaligned <= 1'b0;
      r_bus_err    <= 1'b0;
      r_load_data  <= '0;
    end else begin
      case (r_state)
        LSU_IDLE: begin
          if (start_i) begin
            r_misaligned <= w_misaligned;
            r_bus_err    <= 1'b0;
            r_count      <= '0;
            if (w_op.is_mem && !w_misaligned) begin
              r_addr       <= address_i;
              r_store_data <= rs2_val_i;
              r_is_store   <= w_op.is_store;
              r_signed     <= w_op.is_signed;
              r_size       <= w_op.size;
              r_state      <= LSU_REQ;
            end else begin
              r_state <= LSU_DONE;
            end
          end
        end
        LSU_REQ: begin
          if (w_timeout) begin
            r_bus_err <= 1'b1;
            r_state   <= LSU_DONE;
          end else if (mem_ready_i) begin
            if (!r_is_store) begin
              r_load_data <= w_load_data;
            end
            r_state <= LSU_DONE;
          end else begin
            r_count <= r_count + 8'd1;
          end
        end
        default: r_state <= LSU_IDLE;
      endcase
    end
  end

  assign mem_req_o    = w_req;
  assign mem_we_o     = w_wr;
  assign mem_addr_o   = w_req ? {r_addr[31:2], 2'b00} : 32'd0;
  assign mem_wdata_o  = w_wr ? w_wdata : 32'd0;
  assign mem_wstrb_o  = w_wr ? w_wstrb : 4'd0;
  assign load_data_o  = r_load_data;
  assign done_o       = (r_state == LSU_DONE);
  assign busy_o       = (r_state != LSU_IDLE);
  assign misaligned_o = r_misaligned;
  assign bus_err_o    = r_bus_err;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed self-checking bench for lsu
module tb_lsu;
  import lsu_pkg::*;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [DECODE_W-1:0] dec = '0;
  logic [31:0]         addr = '0;
  logic [31:0]         rs2 = '0;
  logic                mem_ready = 1'b0;
  logic [31:0]         mem_rdata = '0;
  logic                mem_req, mem_we, done, busy, misaligned, bus_err;
  logic [31:0]         mem_addr, mem_wdata, load_data;
  logic [3:0]          mem_wstrb;

  int n_tests = 0;
  int n_fail  = 0;

  lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .decode_net_i (dec),
    .address_i    (addr),
    .rs2_val_i    (rs2),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_wstrb_o  (mem_wstrb),
    .mem_ready_i  (mem_ready),
    .mem_rdata_i  (mem_rdata),
    .load_data_o  (load_data),
    .done_o       (done),
    .busy_o       (busy),
    .misaligned_o (misaligned),
    .bus_err_o    (bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Pulse start for one cycle, then scramble the inputs; returns mid-cycle N+1
  task automatic start_op(input int bit_idx, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    start = 1'b1;
    dec   = '0;
    if (bit_idx >= 0) dec[bit_idx] = 1'b1;
    addr  = a;
    rs2   = d;
    @(negedge clk);
    start = 1'b0;
    dec   = '0;
    addr  = 32'hFFFF_FFFF;
    rs2   = 32'h5555_5555;
  endtask

  // Single-cycle load with ready in the first REQ cycle; returns mid DONE cycle
  task automatic quick_load(input string tag, input int bit_idx, input logic [31:0] a,
                            input logic [31:0] rdata, input logic [31:0] exp);
    start_op(bit_idx, a, 32'h0);
    mem_ready = 1'b1;
    mem_rdata = rdata;
    check({tag, "_wstrb"}, 32'(mem_wstrb), 32'h0);
    check({tag, "_we"}, 32'(mem_we), 32'h0);
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    check({tag, "_done"}, 32'(done), 32'h1);
    check({tag, "_data"}, load_data, exp);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req", 32'(mem_req), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_load", load_data, 32'h0);
    rst = 1'b0;

    // SW aligned, ready immediately
    start_op(IS_SW, 32'h100, 32'hDEAD_BEEF);
    mem_ready = 1'b1;
    check("sw_req", 32'(mem_req), 32'h1);
    check("sw_we", 32'(mem_we), 32'h1);
    check("sw_addr", mem_addr, 32'h100);
    check("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("sw_wstrb", 32'(mem_wstrb), 32'hF);
    @(negedge clk);
    mem_ready = 1'b0;
    check("sw_done", 32'(done), 32'h1);
    check("sw_flags", {30'd0, misaligned, bus_err}, 32'h0);
    @(negedge clk);
    check("sw_done_once", 32'(done), 32'h0);
    check("sw_idle", 32'(busy), 32'h0);

    // SB to top byte lane
    start_op(IS_SB, 32'h103, 32'h0000_00A5);
    mem_ready = 1'b1;
    check("sb_addr", mem_addr, 32'h100);
    check("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    check("sb_wstrb", 32'(mem_wstrb), 32'h8);
    @(negedge clk);
    mem_ready = 1'b0;
    check("sb_done", 32'(done), 32'h1);

    // Loads with sign/zero extension
    quick_load("lb", IS_LB, 32'h103, 32'h8000_0000, 32'hFFFF_FF80);
    quick_load("lbu", IS_LBU, 32'h103, 32'h8000_0000, 32'h0000_0080);
    quick_load("lh", IS_LH, 32'h102, 32'h8001_1234, 32'hFFFF_8001);
    quick_load("lw", IS_LW, 32'h204, 32'h1234_5678, 32'h1234_5678);

    // LHU with three wait cycles and an ignored start while busy
    start_op(IS_LHU, 32'h102, 32'h0);
    mem_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("lhu_req%0d", i), 32'(mem_req), 32'h1);
      check($sformatf("lhu_addr%0d", i), mem_addr, 32'h100);
      check($sformatf("lhu_we%0d", i), 32'(mem_we), 32'h0);
      check($sformatf("lhu_done%0d", i), 32'(done), 32'h0);
      if (i == 1) begin
        start = 1'b1;
        dec[IS_SW] = 1'b1;
        addr = 32'h400;
      end
      @(negedge clk);
      start = 1'b0;
      dec = '0;
    end
    mem_ready = 1'b1;
    mem_rdata = 32'hBEEF_1234;
    check("lhu_req3", 32'(mem_req), 32'h1);
    check("lhu_addr3", mem_addr, 32'h100);
    check("lhu_done3", 32'(done), 32'h0);
    @(negedge clk);
    mem_ready = 1'b0;
    check("lhu_done", 32'(done), 32'h1);
    check("lhu_data", load_data, 32'h0000_BEEF);
    @(negedge clk);
    check("lhu_idle", 32'(busy), 32'h0);
    check("lhu_no_req", 32'(mem_req), 32'h0);

    // Misaligned LW: no request, done at N+1
    start_op(IS_LW, 32'h101, 32'h0);
    check("mis_req", 32'(mem_req), 32'h0);
    check("mis_done", 32'(done), 32'h1);
    check("mis_flag", 32'(misaligned), 32'h1);
    check("mis_load_held", load_data, 32'h0000_BEEF);
    @(negedge clk);
    check("mis_done_once", 32'(done), 32'h0);

    // Non-memory op clears flags
    start_op(0, 32'h100, 32'h0);
    check("nop_done", 32'(done), 32'h1);
    check("nop_flags", {30'd0, misaligned, bus_err}, 32'h0);
    check("nop_load_held", load_data, 32'h0000_BEEF);

    // Timeout with ready never asserted
    start_op(IS_LW, 32'h200, 32'h0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("to_req%0d", i), 32'(mem_req), 32'h1);
      @(negedge clk);
    end
    check("to_req_drop", 32'(mem_req), 32'h0);
    check("to_not_done", 32'(done), 32'h0);
    @(negedge clk);
    check("to_done", 32'(done), 32'h1);
    check("to_bus_err", 32'(bus_err), 32'h1);
    check("to_load_held", load_data, 32'h0000_BEEF);
    @(negedge clk);
    check("to_idle", 32'(busy), 32'h0);

    // Reset during REQ drops the request at once, no done pulse
    start_op(IS_SW, 32'h300, 32'h1111_2222);
    check("rr_req", 32'(mem_req), 32'h1);
    #2 rst = 1'b1;
    #1 check("rr_req_drop", 32'(mem_req), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rr_no_done%0d", i), 32'(done), 32'h0);
      @(negedge clk);
    end
    check("rr_idle", 32'(busy), 32'h0);
    check("rr_load", load_data, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
